// File: rtl/lbdr_input_fifo.sv
// Per-input-port flit buffer ahead of the LBDR routing stage: first-word-fall-through
// FIFO with head-flit decode and a sticky packet-framing checker on the write side.
module lbdr_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     ready_out,
    input  logic                     read_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [2:0]               flit_id,
    output logic [3:0]               dst_addr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [2:0] FLIT_HEADER  = 3'b001;
    localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [2:0] FLIT_TAIL    = 3'b100;

    typedef enum logic {
        IDLE,
        IN_PKT
    } frame_state_t;

    frame_state_t          frame_state;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_fire;
    logic                  rd_fire;
    logic [2:0]            in_id;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count     = wr_ptr - rd_ptr;
    assign ready_out = ~full;

    assign wr_fire = valid_in & ~full;
    assign rd_fire = read_en & ~empty;
    assign in_id   = data_in[DATA_WIDTH-1 -: 3];

    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign flit_id  = data_out[DATA_WIDTH-1 -: 3];
    assign dst_addr = data_out[DATA_WIDTH-4 -: 4];

    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Framing checker: advances only on accepted writes; offending flits are still stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_state <= IDLE;
            frame_err   <= 1'b0;
        end else if (wr_fire) begin
            case (frame_state)
                IDLE: begin
                    if (in_id == FLIT_HEADER) frame_state <= IN_PKT;
                    else                      frame_err   <= 1'b1;
                end
                IN_PKT: begin
                    if (in_id == FLIT_TAIL)         frame_state <= IDLE;
                    else if (in_id != FLIT_PAYLOAD) frame_err   <= 1'b1;
                end
                default: frame_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lbdr_input_fifo.md
# lbdr_input_fifo

Per-input-port flit buffer of the NoC router, directly upstream of the LBDR routing stage. Accepts flits from the link with a valid/ready handshake, stores up to DEPTH flits in order, and presents the head flit first-word-fall-through, together with `empty`, the decoded `flit_id` and `dst_addr` that LBDR samples. It also checks packet framing on the write side and flags violations.

## Interface
- DATA_WIDTH, 32: flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-3] are flit_id. Bits [DATA_WIDTH-4:DATA_WIDTH-7] are dst_addr.
- DEPTH, 4: number of entries. Must be a power of 2, ≥2.
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- valid_in  input  1  upstream presents a flit
- data_in  input  DATA_WIDTH  incoming flit
- ready_out  output  1  = ~full; write accepted iff valid_in & ready_out
- read_en  input  1  downstream pops head flit
- data_out  output  DATA_WIDTH  head flit (FWFT); all-zero when empty
- flit_id  output  3  data_out[DATA_WIDTH-1 -: 3]
- dst_addr  output  4  data_out[DATA_WIDTH-4 -: 4]
- empty  output  1  no stored flit
- full  output  1  DEPTH flits stored
- count  output  $clog2(DEPTH)+1  occupancy 0..DEPTH
- frame_err  output  1  sticky framing-violation flag

## Operation
- Storage: DEPTH×DATA_WIDTH register array. Write and read pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - empty when pointers are equal.
  - full when the index bits are equal and the MSBs differ.
  - count = wr_ptr − rd_ptr, modulo 2^(log2 DEPTH + 1).
- Write: if valid_in & ~full, store data_in at wr_ptr and increment wr_ptr. If valid_in & full, drop the flit with no state change; upstream must hold it.
- Read: if read_en & ~empty, increment rd_ptr. read_en while empty is ignored.
- Simultaneous write and read:
  - Neither full nor empty: both occur; count unchanged.
  - Full: only the read occurs. full is evaluated before the pop, so the write is refused this cycle.
  - Empty: only the write occurs; the new flit appears at data_out next cycle.
- Flit types use the shared encodings: HEADER 3'b001, PAYLOAD 3'b010, TAIL 3'b100.
- Framing checker: two-state FSM on accepted writes.
  - IDLE: HEADER goes to IN_PKT. PAYLOAD, TAIL, or any other code sets frame_err and stays IDLE.
  - IN_PKT: PAYLOAD stays. TAIL goes to IDLE. HEADER or an illegal code sets frame_err and stays IN_PKT.
  - A flit that sets frame_err is still stored. Only rst clears frame_err.
- Reset values: wr_ptr=rd_ptr=0, empty=1, full=0, ready_out=1, count=0, data_out=0, flit_id=0, dst_addr=0, frame_err=0, FSM=IDLE. Array contents are not cleared.
- Reset mid-operation: rst has priority over valid_in and read_en in the same cycle. All stored flits are discarded.

## Timing
- Write-to-read latency is 1 cycle. A flit accepted at edge N is visible on data_out, with empty=0, after edge N. It can be popped at edge N+1.
- empty, full, count, ready_out and data_out are derived combinationally from the registered pointers and array. There is no output register stage.
- LBDR samples empty, flit_id and dst_addr at the same edge where read_en pops the flit.
- Throughput is 1 flit/cycle in each direction when neither full nor empty.
- frame_err asserts the cycle after the offending write is accepted.

## Test plan
- Reset then idle: empty=1, full=0, count=0, ready_out=1, data_out=0, frame_err=0.
- Single packet, DEPTH=4: write HEADER(dst=4'hA), PAYLOAD, TAIL on consecutive cycles, then pop one per cycle.
  - After first write: flit_id=3'b001, dst_addr=4'hA.
  - Pops return the flits in order; empty=1 after the third pop.
  - frame_err stays 0.
- Fill to full:
  - Write 5 flits back-to-back: full=1 and count=4 after the 4th, ready_out=0, 5th flit not stored.
  - Then read and write in the same cycle while full: count drops to 3; the written flit is refused.
- Wrap-around: 10 write/read pairs with occupancy held at 2 (pointers wrap more than twice). Data order is preserved, and count stays 2 during the steady write/read cycles.
- Simultaneous read+write while empty: read ignored, count becomes 1, data_out equals the written flit next cycle.
- Framing:
  - PAYLOAD while IDLE sets frame_err=1 the next cycle and the flit is stored.
  - HEADER followed by HEADER sets frame_err.
  - rst mid-packet clears frame_err, count and empty back to reset values.
